// File: rtl/sprite_reg_shadow.sv
// Sprite register shadow: staging registers written over Avalon, copied
// to the live set on a vsync falling edge once a commit is pending.
//
// Ports:
//   clk, reset        - system clock, async active-low reset
//   chipselect, write, read, address[8:0], writedata[31:0], readdata[31:0]
//                     - Avalon-MM slave (readdata registered, 1-cycle latency)
//   VGA_VS            - active-low vertical sync from the timing counters
//   dino_x .. score_y - live sprite/score registers to the renderer
//   frame_tick        - one-cycle pulse on each vsync falling edge
module sprite_reg_shadow (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [8:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        VGA_VS,
  output logic [7:0]  dino_x,
  output logic [7:0]  dino_y,
  output logic [7:0]  jump_x,
  output logic [7:0]  jump_y,
  output logic [7:0]  duck_x,
  output logic [7:0]  duck_y,
  output logic [7:0]  s_cac_x,
  output logic [7:0]  s_cac_y,
  output logic [7:0]  godzilla_x,
  output logic [7:0]  godzilla_y,
  output logic [3:0]  score,
  output logic [7:0]  score_x,
  output logic [7:0]  score_y,
  output logic        frame_tick
);

  // The 12 byte-wide position registers live in one array; the
  // 4-bit score digit is kept apart. Array index = address, except
  // addresses 11/12 (score_x/score_y) shift down by one.
  localparam int         NPOS     = 12;
  localparam logic [8:0] A_SCORE  = 9'd10;
  localparam logic [8:0] A_LAST   = 9'd12;
  localparam logic [8:0] A_CTRL   = 9'd13;
  localparam logic [8:0] A_STATUS = 9'd14;
  localparam logic [8:0] A_FRAMES = 9'd15;

  function automatic logic [7:0] pos_rst(input int i);
    logic [7:0] v;
    case (i)
      0:       v = 8'd100;
      1:       v = 8'd100;
      2:       v = 8'd200;
      3:       v = 8'd150;
      4:       v = 8'd44;
      5:       v = 8'd200;
      6:       v = 8'd244;
      7:       v = 8'd100;
      8:       v = 8'd100;
      9:       v = 8'd4;
      10:      v = 8'd35;
      11:      v = 8'd185;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  logic [7:0]  r_stg  [NPOS];
  logic [7:0]  r_live [NPOS];
  logic [3:0]  r_stg_score;
  logic [3:0]  r_live_score;
  logic        r_vs_q;
  logic        r_armed;
  logic        r_pending;
  logic [15:0] r_frames;

  logic        w_wr;
  logic        w_rd;
  logic        w_is_reg;
  logic [3:0]  w_pidx;
  logic        w_wr_pos;
  logic        w_wr_score;
  logic        w_wr_ctrl;
  logic [3:0]  w_score_sat;
  logic        w_edge;
  logic        w_commit;
  logic [31:0] w_rdata;
  logic        w_unused_wdata;

  assign w_wr     = chipselect & write;
  assign w_rd     = chipselect & read;
  assign w_is_reg = (address <= A_LAST);
  assign w_pidx   = (address[3:0] < 4'd10) ? address[3:0]
                                           : address[3:0] - 4'd1;

  assign w_wr_pos   = w_wr & w_is_reg & (address != A_SCORE);
  assign w_wr_score = w_wr & (address == A_SCORE);
  assign w_wr_ctrl  = w_wr & (address == A_CTRL);

  assign w_score_sat = (writedata[3:0] > 4'd9) ? 4'd9
                                               : writedata[3:0];

  assign w_unused_wdata = ^writedata[31:8];

  // r_armed masks the first cycle after reset release, where vs_q
  // still holds its reset value of 1 and could fake an edge.
  assign w_edge     = r_armed & r_vs_q & ~VGA_VS;
  assign w_commit   = w_edge & r_pending;
  assign frame_tick = w_edge;

  // Staging set: host-visible, written directly by the bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NPOS; i++) begin
        r_stg[i] <= pos_rst(i);
      end
      r_stg_score <= 4'd0;
    end else begin
      if (w_wr_pos) begin
        r_stg[w_pidx] <= writedata[7:0];
      end
      if (w_wr_score) begin
        r_stg_score <= w_score_sat;
      end
    end
  end

  // Live set: loads the pre-write staging values on a committing
  // edge, so a same-cycle bus write lands only in staging.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NPOS; i++) begin
        r_live[i] <= pos_rst(i);
      end
      r_live_score <= 4'd0;
    end else if (w_commit) begin
      for (int i = 0; i < NPOS; i++) begin
        r_live[i] <= r_stg[i];
      end
      r_live_score <= r_stg_score;
    end
  end

  // A CTRL write always decides the final pending state; the commit
  // itself is gated by the pending value from before the write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vs_q    <= 1'b1;
      r_armed   <= 1'b0;
      r_pending <= 1'b0;
      r_frames  <= 16'd0;
      readdata  <= 32'd0;
    end else begin
      r_vs_q  <= VGA_VS;
      r_armed <= 1'b1;
      if (w_edge) begin
        r_frames <= r_frames + 16'd1;
      end
      if (w_wr_ctrl) begin
        r_pending <= writedata[0];
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end
      if (w_rd) begin
        readdata <= w_rdata;
      end
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    unique case (1'b1)
      w_is_reg && (address == A_SCORE):
        w_rdata[3:0] = r_stg_score;
      w_is_reg && (address != A_SCORE):
        w_rdata[7:0] = r_stg[w_pidx];
      address == A_STATUS:
        w_rdata[0] = r_pending;
      address == A_FRAMES:
        w_rdata[15:0] = r_frames;
      default: ;
    endcase
  end

  assign dino_x     = r_live[0];
  assign dino_y     = r_live[1];
  assign jump_x     = r_live[2];
  assign jump_y     = r_live[3];
  assign duck_x     = r_live[4];
  assign duck_y     = r_live[5];
  assign s_cac_x    = r_live[6];
  assign s_cac_y    = r_live[7];
  assign godzilla_x = r_live[8];
  assign godzilla_y = r_live[9];
  assign score      = r_live_score;
  assign score_x    = r_live[10];
  assign score_y    = r_live[11];

endmodule

// File: tb/tb_sprite_reg_shadow.sv
// Testbench for sprite_reg_shadow: directed stimulus pushes expected
// values into a queue, a negedge monitor pops and compares.
module tb_sprite_reg_shadow;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [8:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        VGA_VS;
  logic [7:0]  dino_x, dino_y, jump_x, jump_y, duck_x, duck_y;
  logic [7:0]  s_cac_x, s_cac_y, godzilla_x, godzilla_y;
  logic [3:0]  score;
  logic [7:0]  score_x, score_y;
  logic        frame_tick;

  always #10 clk = ~clk;

  sprite_reg_shadow dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .write      (write),
    .read       (read),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .VGA_VS     (VGA_VS),
    .dino_x     (dino_x),
    .dino_y     (dino_y),
    .jump_x     (jump_x),
    .jump_y     (jump_y),
    .duck_x     (duck_x),
    .duck_y     (duck_y),
    .s_cac_x    (s_cac_x),
    .s_cac_y    (s_cac_y),
    .godzilla_x (godzilla_x),
    .godzilla_y (godzilla_y),
    .score      (score),
    .score_x    (score_x),
    .score_y    (score_y),
    .frame_tick (frame_tick)
  );

  typedef struct {
    string       nm;
    int          src;
    logic [31:0] exp;
  } item_t;

  localparam int SRC_RD   = -1;
  localparam int SRC_TICK = 13;

  item_t sbq[$];
  int    checks     = 0;
  int    errors     = 0;
  int    tick_cnt   = 0;
  int    exp_ticks  = 0;
  int    exp_frames = 0;

  // Reset values in address order (score digit at index 10).
  int RST [13] = '{100, 100, 200, 150, 44, 200, 244, 100,
                   100, 4, 0, 35, 185};

  function automatic logic [31:0] live_of(input int i);
    case (i)
      0:       return {24'd0, dino_x};
      1:       return {24'd0, dino_y};
      2:       return {24'd0, jump_x};
      3:       return {24'd0, jump_y};
      4:       return {24'd0, duck_x};
      5:       return {24'd0, duck_y};
      6:       return {24'd0, s_cac_x};
      7:       return {24'd0, s_cac_y};
      8:       return {24'd0, godzilla_x};
      9:       return {24'd0, godzilla_y};
      10:      return {28'd0, score};
      11:      return {24'd0, score_x};
      12:      return {24'd0, score_y};
      default: return 32'd0;
    endcase
  endfunction

  // Monitor: counts frame_tick pulses and drains the scoreboard.
  always @(negedge clk) begin
    item_t       it;
    logic [31:0] act;
    if (frame_tick === 1'b1) tick_cnt++;
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      if (it.src == SRC_RD)        act = readdata;
      else if (it.src == SRC_TICK) act = tick_cnt;
      else                         act = live_of(it.src);
      checks++;
      if (act !== it.exp) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", it.nm, act, it.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string nm, input int src,
                          input logic [31:0] e);
    item_t it;
    it.nm  = nm;
    it.src = src;
    it.exp = e;
    sbq.push_back(it);
  endtask

  task automatic wr(input logic [8:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic rd(input logic [8:0] a, input logic [31:0] e,
                    input string nm);
    chipselect = 1'b1;
    read       = 1'b1;
    address    = a;
    tick();
    chipselect = 1'b0;
    read       = 1'b0;
    expect_v(nm, SRC_RD, e);
  endtask

  // One vsync falling edge, optionally with a bus write in the
  // edge cycle itself.
  task automatic edge_op(input bit do_wr, input logic [8:0] a,
                         input logic [31:0] d);
    VGA_VS = 1'b1;
    tick();
    VGA_VS = 1'b0;
    if (do_wr) begin
      chipselect = 1'b1;
      write      = 1'b1;
      address    = a;
      writedata  = d;
    end
    tick();
    chipselect = 1'b0;
    write      = 1'b0;
    exp_frames = (exp_frames + 1) & 32'hFFFF;
    exp_ticks++;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset      = 1'b0;
    chipselect = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
    address    = 9'd0;
    writedata  = 32'd0;
    VGA_VS     = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 13; i++)
      expect_v($sformatf("rst_live%0d", i), i, RST[i]);
    expect_v("rst_rdata", SRC_RD, 32'd0);
    chipselect = 1'b1;
    read       = 1'b1;
    address    = 9'd0;
    tick();
    chipselect = 1'b0;
    read       = 1'b0;
    expect_v("rst_rd_hold", SRC_RD, 32'd0);

    // Release with VGA_VS already low: no edge may be seen.
    VGA_VS = 1'b0;
    tick();
    reset = 1'b1;
    repeat (2) tick();
    VGA_VS = 1'b1;
    tick();
    expect_v("rel_tick", SRC_TICK, 32'd0);
    rd(9'd15, 32'd0, "rel_frames");

    // Staging write without commit.
    wr(9'd0, 32'd50);
    repeat (1000) tick();
    expect_v("hold_dino_x", 0, 32'd100);
    rd(9'd0, 32'd50, "stg_dino_x");
    rd(9'd14, 32'd0, "hold_status");

    // Commit on the next edge.
    wr(9'd13, 32'd1);
    rd(9'd14, 32'd1, "status_pend");
    edge_op(1'b0, 9'd0, 32'd0);
    expect_v("commit_dino_x", 0, 32'd50);
    expect_v("commit_dino_y", 1, 32'd100);
    rd(9'd14, 32'd0, "status_clr");
    rd(9'd15, exp_frames, "frames_1");
    repeat (3) tick();
    expect_v("tick_once", SRC_TICK, exp_ticks);

    // Truncation and score saturation.
    wr(9'd1, 32'h0000_01FF);
    rd(9'd1, 32'hFF, "trunc_dino_y");
    wr(9'd10, 32'd7);
    rd(9'd10, 32'd7, "score_stg7");
    wr(9'd10, 32'd12);
    rd(9'd10, 32'd9, "score_sat");
    wr(9'd13, 32'd1);
    edge_op(1'b0, 9'd0, 32'd0);
    expect_v("score_live", 10, 32'd9);
    expect_v("dino_y_live", 1, 32'd255);

    // Staging write in the committing edge cycle.
    wr(9'd2, 32'd10);
    wr(9'd13, 32'd1);
    edge_op(1'b1, 9'd2, 32'd20);
    expect_v("same_jump_x_live", 2, 32'd10);
    rd(9'd2, 32'd20, "same_jump_x_stg");
    rd(9'd14, 32'd0, "same_status");

    // CTRL=1 on the edge cycle arms the following edge only.
    edge_op(1'b1, 9'd13, 32'd1);
    expect_v("ctrl1_edge_live", 2, 32'd10);
    rd(9'd14, 32'd1, "ctrl1_edge_pend");
    edge_op(1'b0, 9'd0, 32'd0);
    expect_v("ctrl1_next_live", 2, 32'd20);
    rd(9'd14, 32'd0, "ctrl1_next_status");

    // CTRL=0 on a committing edge: commit still happens.
    wr(9'd3, 32'd77);
    wr(9'd13, 32'd1);
    edge_op(1'b1, 9'd13, 32'd0);
    expect_v("ctrl0_jump_y", 3, 32'd77);
    rd(9'd14, 32'd0, "ctrl0_status");

    // Cancel before the edge.
    wr(9'd4, 32'd1);
    wr(9'd13, 32'd1);
    wr(9'd13, 32'd0);
    edge_op(1'b0, 9'd0, 32'd0);
    expect_v("cancel_duck_x", 4, 32'd44);
    rd(9'd14, 32'd0, "cancel_status");

    // Writes to read-only and unmapped addresses.
    wr(9'd14, 32'd1);
    wr(9'd15, 32'd5);
    wr(9'd200, 32'd7);
    wr(9'd511, 32'd9);
    rd(9'd14, 32'd0, "ro_status");
    rd(9'd15, exp_frames, "ro_frames");
    rd(9'd200, 32'd0, "rd_200");
    rd(9'd13, 32'd0, "rd_ctrl");
    rd(9'd8, 32'd100, "stg_gx_kept");
    rd(9'd0, 32'd50, "stg_dino_x2");
    tick();
    expect_v("rd_hold", SRC_RD, 32'd50);

    // Frame counter wrap from a preloaded value.
    force dut.r_frames = 16'hFFFE;
    tick();
    release dut.r_frames;
    exp_frames = 32'hFFFE;
    rd(9'd15, 32'hFFFE, "frames_pre");
    edge_op(1'b0, 9'd0, 32'd0);
    rd(9'd15, 32'hFFFF, "frames_max");
    edge_op(1'b0, 9'd0, 32'd0);
    rd(9'd15, exp_frames, "frames_wrap");
    rd(9'd200, 32'd0, "rd_200b");

    // Reset mid-frame discards a pending commit.
    wr(9'd5, 32'd9);
    wr(9'd13, 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp_frames = 0;
    edge_op(1'b0, 9'd0, 32'd0);
    for (int i = 0; i < 13; i++)
      expect_v($sformatf("mid_rst_live%0d", i), i, RST[i]);
    rd(9'd14, 32'd0, "mid_rst_status");
    rd(9'd5, 32'd200, "mid_rst_stg");
    rd(9'd15, exp_frames, "mid_rst_frames");
    expect_v("tick_total", SRC_TICK, exp_ticks);

    repeat (3) tick();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
